// File: rtl/bn_backward_sched.sv
// bn_backward_sched: walks channels 0..num_ch-1 for the shared batch-norm
// backward engine. For each channel it fetches the statistics, launches
// the engine, hands the gradients downstream and then releases the engine.
// Optional feature macro: BN_SCHED_WDOG_EN adds a WAIT-state watchdog that
// raises a sticky error and abandons the run if the engine never finishes.
module bn_backward_sched #(
    parameter int IL       = 4,
    parameter int FL       = 16,
    parameter int CH_W     = 8,
    parameter int WDOG_CYC = 64,
    localparam int W       = IL + FL
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CH_W-1:0] num_ch,
    input  logic [4:0]      batch_num,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            prm_rd_en,
    output logic [CH_W-1:0] prm_addr,
    input  logic [W-1:0]    prm_mu,
    input  logic [W-1:0]    prm_vari,
    input  logic [W-1:0]    prm_gamma,
    output logic [4:0]      eng_num,
    output logic [W-1:0]    eng_mu,
    output logic [W-1:0]    eng_vari,
    output logic [W-1:0]    eng_gamma,
    output logic            eng_input_ready,
    output logic            eng_output_taken,
    input  logic            eng_done,
    input  logic [W-1:0]    eng_dgamma,
    input  logic [W-1:0]    eng_dbeta,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [CH_W-1:0] res_ch,
    output logic [W-1:0]    res_dgamma,
    output logic [W-1:0]    res_dbeta
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        KICK,
        WAIT,
        EMIT,
        RELEASE,
        FIN
    } state_t;

    localparam logic [CH_W-1:0] CH_ONE = 1;

    state_t          state;
    state_t          state_d;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] num_ch_r;
    logic            last_ch;

    // The last channel is judged against the count sampled at start, so
    // num_ch may change freely while a run is in progress.
    assign last_ch  = (ch == (num_ch_r - CH_ONE));
    assign prm_addr = ch;

`ifdef BN_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC) + 1;
    localparam logic [WD_W-1:0] WD_ONE  = 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_expired;
    logic            error_r;

    assign wdog_expired = (state == WAIT) && !eng_done && (wdog_cnt == WD_LAST);
    assign error        = error_r;

    // Count cycles spent in WAIT and latch a sticky error on expiry; a new
    // accepted start is the only thing that clears the error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
            error_r  <= 1'b0;
        end else begin
            wdog_cnt <= (state == WAIT) ? (wdog_cnt + WD_ONE) : '0;
            if ((state == IDLE) && start) begin
                error_r <= 1'b0;
            end else if (wdog_expired) begin
                error_r <= 1'b1;
            end
        end
    end
`else
    assign error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state decode and the one-cycle control strobes of each state.
    always_comb begin
        state_d          = state;
        busy             = (state != IDLE);
        done             = 1'b0;
        prm_rd_en        = 1'b0;
        eng_input_ready  = 1'b0;
        eng_output_taken = 1'b0;
        res_valid        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = (num_ch == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                prm_rd_en = 1'b1;
                state_d   = LOAD;
            end
            LOAD: begin
                state_d = KICK;
            end
            KICK: begin
                eng_input_ready = 1'b1;
                state_d         = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    state_d = EMIT;
                end
`ifdef BN_SCHED_WDOG_EN
                else if (wdog_expired) begin
                    eng_output_taken = 1'b1;
                    state_d          = FIN;
                end
`endif
            end
            EMIT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                eng_output_taken = 1'b1;
                state_d          = last_ch ? FIN : FETCH;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath registers: run parameters, engine operands and the result
    // copy; data words pass through bit-exact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch         <= '0;
            num_ch_r   <= '0;
            eng_num    <= '0;
            eng_mu     <= '0;
            eng_vari   <= '0;
            eng_gamma  <= '0;
            res_ch     <= '0;
            res_dgamma <= '0;
            res_dbeta  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ch       <= '0;
                        num_ch_r <= num_ch;
                        eng_num  <= batch_num;
                    end
                end
                LOAD: begin
                    eng_mu    <= prm_mu;
                    eng_vari  <= prm_vari;
                    eng_gamma <= prm_gamma;
                end
                WAIT: begin
                    if (eng_done) begin
                        res_ch     <= ch;
                        res_dgamma <= eng_dgamma;
                        res_dbeta  <= eng_dbeta;
                    end
                end
                RELEASE: begin
                    if (!last_ch) begin
                        ch <= ch + CH_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/bn_backward_sched.md
# bn_backward_sched

Channel scheduler for the batch-normalization backward engine (`backward`). On a start pulse it walks channels 0..num_ch-1. For each channel it:
- fetches per-channel statistics (mu, vari, gamma) from a parameter buffer;
- loads them into the engine and launches it with `input_ready`;
- waits for `done`, then hands (dgamma, dbeta) to a downstream gradient writer over a valid/ready stream;
- releases the engine with `output_taken`.

It sits between the training-step controller and the shared `backward` instance.

## Interface
Parameters:
- IL, 4, integer bits of fixed-point words
- FL, 16, fraction bits; word width W = IL+FL
- CH_W, 8, channel index / count width
- WDOG_CYC, 64, watchdog limit in cycles (used only with BN_SCHED_WDOG_EN)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle launch request; ignored while busy
- num_ch  in  CH_W  channels to process; sampled on accepted start
- batch_num  in  5  batch size; sampled on start, driven to engine `num`
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- error  out  1  sticky watchdog flag; cleared on next accepted start
- prm_rd_en  out  1  parameter-buffer read strobe
- prm_addr  out  CH_W  channel being read
- prm_mu, prm_vari, prm_gamma  in  W  read data, valid exactly 1 cycle after prm_rd_en
- eng_num  out  5  to engine `num`
- eng_mu, eng_vari, eng_gamma  out  W  to engine, held stable through the channel
- eng_input_ready  out  1  one-cycle engine launch
- eng_output_taken  out  1  one-cycle engine release
- eng_done  in  1  engine result valid; level, held until output_taken
- eng_dgamma, eng_dbeta  in  W  engine results
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts
- res_ch  out  CH_W  channel index of result
- res_dgamma, res_dbeta  out  W  registered copies of the engine results

## Operation
- States: IDLE, FETCH, LOAD, KICK, WAIT, EMIT, RELEASE, FIN.
- IDLE:
  - start with num_ch≠0 → FETCH; ch←0, error←0.
  - start with num_ch=0 → FIN; the engine and parameter buffer are never touched.
- FETCH: prm_rd_en=1, prm_addr=ch → LOAD.
- LOAD: capture prm_* into eng_mu/vari/gamma registers → KICK.
- KICK: eng_input_ready=1 → WAIT.
- WAIT:
  - stay until eng_done=1.
  - On eng_done: capture eng_dgamma/dbeta into res_*, res_ch←ch → EMIT.
- EMIT:
  - res_valid=1 and res_* stay stable until res_valid&res_ready.
  - On that handshake → RELEASE.
- RELEASE: eng_output_taken=1.
  - If ch==num_ch-1 → FIN.
  - Otherwise ch←ch+1 → FETCH.
- FIN: done=1, busy drops → IDLE.
- Results are passed through bit-exact; no arithmetic on data words. ch compare uses the sampled num_ch.
- num_ch=2^CH_W-1 is the maximum; ch never wraps.
- start in any state other than IDLE (including FIN) is ignored.

## Timing
- Reset values:
  - state=IDLE, ch=0.
  - Outputs busy, done, error, prm_rd_en, eng_input_ready, eng_output_taken, res_valid = 0.
  - All address and data outputs = 0.
- Reset mid-run: immediate return to IDLE. No done pulse, no output_taken. The engine is expected to be reset by the same reset.
- Start accepted on edge k → busy=1 and prm_rd_en=1 from cycle k+1.
- Per-channel overhead with res_ready=1 is 5 cycles (FETCH, LOAD, KICK, EMIT, RELEASE) plus engine latency L. Run time = num_ch·(5+L)+1 cycles, including the FIN cycle.
- eng_input_ready and eng_output_taken are never high in the same cycle, and each is high for exactly one cycle per channel.
- res_ready deasserted in EMIT stalls indefinitely; eng_done stays held meanwhile.

## Configuration
- BN_SCHED_WDOG_EN defined:
  - a counter runs in WAIT;
  - after WDOG_CYC cycles without eng_done: error←1, eng_output_taken pulses for one cycle, then FIN (done pulse). Remaining channels are skipped and no result is emitted for the stalled channel.
- Not defined: no counter; WAIT is unbounded; error is tied 0.

## Test plan
- Engine model with L=8; num_ch=3, batch_num=10, res_ready=1 → three results ch 0,1,2 carrying the model's dgamma/dbeta; done pulse 40 cycles after start; three input_ready and three output_taken pulses.
- num_ch=0 start → done pulse one cycle later; prm_rd_en, eng_input_ready and res_valid never assert.
- num_ch=2, res_ready held low 20 cycles during EMIT of ch 0 → res_* stable for all 20 cycles, no output_taken until the handshake, then ch 1 proceeds.
- Start pulsed during WAIT and during FIN → ignored; the run count and the single done pulse are unchanged.
- Assert reset in WAIT of ch 1 → all outputs go to 0 asynchronously, no done pulse; a new start of num_ch=1 completes normally.
- BN_SCHED_WDOG_EN with WDOG_CYC=64 and an engine that never asserts done → error=1, one output_taken pulse, done pulse 64 cycles after entering WAIT; next start clears error.
